// File: rtl/nano_dbg_pkg.sv
// Shared opcodes and FSM state encoding for the SPI debug slave.
package nano_dbg_pkg;

  localparam logic [7:0] OP_READ   = 8'h01;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_HALT   = 8'h03;
  localparam logic [7:0] OP_RESUME = 8'h04;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD_REQ,
    DATA,
    WR_REQ,
    DONE
  } dbg_state_t;

endpackage

// File: rtl/nano_sync2.sv
// Two-flop synchroniser for one asynchronous input bit, with a selectable reset value.
module nano_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nano_dbg_spi_slave.sv
// SPI debug slave: oversamples a mode-0 SPI link, decodes cmd/addr/data frames,
// and turns them into req/ack debug bus accesses plus core halt/resume control.
module nano_dbg_spi_slave
  import nano_dbg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_nano_clk,
  input  logic              i_nano_rst,
  input  logic              i_dbg_spi_en_n,
  input  logic              i_dbg_spi_sclk,
  input  logic              i_dbg_spi_mosi,
  output logic              o_dbg_spi_miso,
  output logic              o_dbg_req,
  output logic              o_dbg_we,
  output logic [ADDR_W-1:0] o_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_wdata,
  input  logic              i_dbg_ack,
  input  logic [DATA_W-1:0] i_dbg_rdata,
  output logic              o_dbg_halt,
  output logic              o_dbg_late
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                           : ((DATA_W > 8) ? DATA_W : 8);
  localparam int CNT_W = $clog2(MAX_W) + 1;

  logic en_s, sclk_s, mosi_s;
  logic en_prev_q, sclk_prev_q;

  nano_sync2 #(.RST_VAL(1'b1)) u_sync_en   (.clk(i_nano_clk), .rst(i_nano_rst), .d(i_dbg_spi_en_n), .q(en_s));
  nano_sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(i_nano_clk), .rst(i_nano_rst), .d(i_dbg_spi_sclk), .q(sclk_s));
  nano_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(i_nano_clk), .rst(i_nano_rst), .d(i_dbg_spi_mosi), .q(mosi_s));

  logic en_fall, en_rise, sclk_rise, sclk_fall;
  assign en_fall   = en_prev_q & ~en_s;
  assign en_rise   = ~en_prev_q & en_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  dbg_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic req_q, req_d, we_q, we_d, halt_q, halt_d, late_q, late_d;
  logic miso_q, miso_d, is_wr_q, is_wr_d, late_seen_q, late_seen_d, abort_q, abort_d;

  logic [7:0] new_cmd;
  logic       abort_now;
  assign new_cmd   = {cmd_q, mosi_s};
  assign abort_now = abort_q | en_rise;

  // A request, once raised, is only ever dropped by ack; an abort seen while
  // waiting is remembered so the FSM returns to IDLE instead of continuing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tx_d        = tx_q;
    req_d       = req_q;
    we_d        = we_q;
    halt_d      = halt_q;
    late_d      = 1'b0;
    miso_d      = miso_q;
    is_wr_d     = is_wr_q;
    late_seen_d = late_seen_q;
    abort_d     = abort_q;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (en_fall) begin
          state_d     = CMD;
          cnt_d       = '0;
          tx_d        = '0;
          late_seen_d = 1'b0;
          abort_d     = 1'b0;
        end
      end
      CMD: begin
        if (en_rise) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          cmd_d = new_cmd[6:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            cnt_d = '0;
            case (new_cmd)
              OP_HALT:   begin halt_d = 1'b1; state_d = DONE; end
              OP_RESUME: begin halt_d = 1'b0; state_d = DONE; end
              OP_READ:   begin is_wr_d = 1'b0; state_d = ADDR; end
              OP_WRITE:  begin is_wr_d = 1'b1; state_d = ADDR; end
              default:   state_d = DONE;
            endcase
          end
        end
      end
      ADDR: begin
        if (en_rise) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          addr_d = {addr_q[ADDR_W-2:0], mosi_s};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_d = '0;
            if (is_wr_q) begin
              state_d = DATA;
            end else begin
              state_d = RD_REQ;
              req_d   = 1'b1;
              we_d    = 1'b0;
            end
          end
        end
      end
      RD_REQ: begin
        if (i_dbg_ack) begin
          req_d   = 1'b0;
          tx_d    = (late_seen_q || abort_now) ? '0 : i_dbg_rdata;
          state_d = abort_now ? IDLE : DATA;
        end else begin
          if (en_rise) abort_d = 1'b1;
          if (sclk_fall && !late_seen_q) begin
            late_d      = 1'b1;
            late_seen_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (en_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end else begin
          if (sclk_fall && !is_wr_q) begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (sclk_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (is_wr_q) wdata_d = {wdata_q[DATA_W-2:0], mosi_s};
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d = '0;
              if (is_wr_q) begin
                state_d = WR_REQ;
                req_d   = 1'b1;
                we_d    = 1'b1;
              end else begin
                state_d = DONE;
                miso_d  = 1'b0;
              end
            end
          end
        end
      end
      WR_REQ: begin
        if (i_dbg_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = abort_now ? IDLE : DONE;
        end else if (en_rise) begin
          abort_d = 1'b1;
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (en_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_nano_clk or posedge i_nano_rst) begin
    if (i_nano_rst) begin
      en_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tx_q        <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      halt_q      <= 1'b0;
      late_q      <= 1'b0;
      miso_q      <= 1'b0;
      is_wr_q     <= 1'b0;
      late_seen_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      en_prev_q   <= en_s;
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tx_q        <= tx_d;
      req_q       <= req_d;
      we_q        <= we_d;
      halt_q      <= halt_d;
      late_q      <= late_d;
      miso_q      <= miso_d;
      is_wr_q     <= is_wr_d;
      late_seen_q <= late_seen_d;
      abort_q     <= abort_d;
    end
  end

  assign o_dbg_spi_miso = miso_q;
  assign o_dbg_req      = req_q;
  assign o_dbg_we       = we_q;
  assign o_dbg_addr     = addr_q;
  assign o_dbg_wdata    = wdata_q;
  assign o_dbg_halt     = halt_q;
  assign o_dbg_late     = late_q;

endmodule

// File: tb/tb_nano_dbg_spi_slave.sv
// Scoreboard bench for nano_dbg_spi_slave: an SPI master drives frames, a bus
// responder checks each request against queued expectations and acks it.
module tb_nano_dbg_spi_slave;

  logic       clk, rst, enN, sclk, mosi, miso;
  logic       req, we, ack, halt, late;
  logic [7:0] addr, wdata, rdata;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } busTxn_t;

  busTxn_t     busQ[$];
  logic [23:0] misoQ[$];

  int         nVec = 0;
  int         nErr = 0;
  int         lateCount = 0;
  int         reqCount = 0;
  int         ackDelay = 1;
  logic [7:0] rdataVal = 8'h00;

  nano_dbg_spi_slave #(.ADDR_W(8), .DATA_W(8)) dut (
    .i_nano_clk     (clk),
    .i_nano_rst     (rst),
    .i_dbg_spi_en_n (enN),
    .i_dbg_spi_sclk (sclk),
    .i_dbg_spi_mosi (mosi),
    .o_dbg_spi_miso (miso),
    .o_dbg_req      (req),
    .o_dbg_we       (we),
    .o_dbg_addr     (addr),
    .o_dbg_wdata    (wdata),
    .i_dbg_ack      (ack),
    .i_dbg_rdata    (rdata),
    .o_dbg_halt     (halt),
    .o_dbg_late     (late)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nVec++;
    if (actual !== expected) begin
      nErr++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI bit: MOSI set during SCLK low, MISO sampled just before SCLK rises.
  task automatic spiBit(input logic b, output logic m);
    mosi = b;
    waitClk(8);
    m    = miso;
    sclk = 1'b1;
    waitClk(8);
    sclk = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] d,
                               input int nbits, input logic [7:0] expData,
                               input bit expBus, input bit expWe);
    logic [23:0] frame, cap, expMiso;
    logic        m;
    frame = {cmd, a, d};
    cap   = '0;
    if (expBus) busQ.push_back('{expWe, a, d});
    misoQ.push_back({16'h0000, expData});
    enN = 1'b0;
    waitClk(8);
    for (int i = 0; i < nbits; i++) begin
      spiBit(frame[23-i], m);
      cap = {cap[22:0], m};
    end
    waitClk(8);
    enN  = 1'b1;
    mosi = 1'b0;
    waitClk(16);
    expMiso = misoQ.pop_front();
    checkOutput($sformatf("miso_cmd%02h", cmd), 32'(cap), 32'(expMiso >> (24 - nbits)));
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_miso"},  32'(miso),  0);
    checkOutput({pfx, "_req"},   32'(req),   0);
    checkOutput({pfx, "_we"},    32'(we),    0);
    checkOutput({pfx, "_addr"},  32'(addr),  0);
    checkOutput({pfx, "_wdata"}, 32'(wdata), 0);
    checkOutput({pfx, "_halt"},  32'(halt),  0);
    checkOutput({pfx, "_late"},  32'(late),  0);
  endtask

  // Bus responder: every new request is popped against the scoreboard, then
  // acked after ackDelay cycles unless reset intervenes.
  initial begin
    busTxn_t expTxn;
    bit      aborted;
    ack   = 1'b0;
    rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && req) begin
        reqCount++;
        if (busQ.size() == 0) begin
          checkOutput("unexpected_req", 1, 0);
        end else begin
          expTxn = busQ.pop_front();
          checkOutput("req_we",   32'(we),   32'(expTxn.we));
          checkOutput("req_addr", 32'(addr), 32'(expTxn.addr));
          if (expTxn.we) checkOutput("req_wdata", 32'(wdata), 32'(expTxn.wdata));
        end
        aborted = 1'b0;
        for (int i = 0; i < ackDelay; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (!req) begin
            checkOutput("req_held", 32'(req), 1);
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          ack   = 1'b1;
          rdata = rdataVal;
          @(negedge clk);
          ack   = 1'b0;
          checkOutput("req_drop", 32'(req), 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (late === 1'b1) begin
      lateCount++;
      checkOutput("late_req_held", 32'(req), 1);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic m;
    rst  = 1'b1;
    enN  = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    waitClk(3);
    checkAllZero("reset");
    rst = 1'b0;
    waitClk(10);

    // WRITE 0x3C <- 0xA5, ack two cycles after request
    ackDelay = 2;
    applyStimulus(8'h02, 8'h3C, 8'hA5, 24, 8'h00, 1'b1, 1'b1);
    checkOutput("t1_req_count", 32'(reqCount), 1);

    // READ 0x10, prompt ack with 0x5A
    ackDelay = 1;
    rdataVal = 8'h5A;
    applyStimulus(8'h01, 8'h10, 8'h00, 24, 8'h5A, 1'b1, 1'b0);
    checkOutput("t2_late_count", 32'(lateCount), 0);

    // READ with ack landing after the first data-phase falling edge
    ackDelay = 12;
    rdataVal = 8'h77;
    applyStimulus(8'h01, 8'h22, 8'h00, 24, 8'h00, 1'b1, 1'b0);
    checkOutput("t3_late_count", 32'(lateCount), 1);
    checkOutput("t3_req_count", 32'(reqCount), 3);

    // HALT, NOP, RESUME, then a truncated HALT
    applyStimulus(8'h03, 8'h00, 8'h00, 8, 8'h00, 1'b0, 1'b0);
    checkOutput("t4_halt_set", 32'(halt), 1);
    applyStimulus(8'h55, 8'h00, 8'h00, 8, 8'h00, 1'b0, 1'b0);
    checkOutput("t4_halt_nop", 32'(halt), 1);
    applyStimulus(8'h04, 8'h00, 8'h00, 8, 8'h00, 1'b0, 1'b0);
    checkOutput("t4_halt_resume", 32'(halt), 0);
    applyStimulus(8'h03, 8'h00, 8'h00, 5, 8'h00, 1'b0, 1'b0);
    checkOutput("t4_halt_partial", 32'(halt), 0);

    // WRITE aborted after 4 data bits, then a full WRITE 0x01 <- 0xFF
    ackDelay = 1;
    applyStimulus(8'h02, 8'h44, 8'h99, 20, 8'h00, 1'b0, 1'b1);
    checkOutput("t5_abort_no_req", 32'(reqCount), 3);
    applyStimulus(8'h02, 8'h01, 8'hFF, 24, 8'h00, 1'b1, 1'b1);
    checkOutput("t5_req_count", 32'(reqCount), 4);

    // Reset asserted while a read request is outstanding
    applyStimulus(8'h03, 8'h00, 8'h00, 8, 8'h00, 1'b0, 1'b0);
    checkOutput("t6_halt_before", 32'(halt), 1);
    ackDelay = 1000;
    busQ.push_back('{1'b0, 8'h10, 8'h00});
    enN = 1'b0;
    waitClk(8);
    for (int i = 0; i < 16; i++) begin
      spiBit((i == 7 || i == 11) ? 1'b1 : 1'b0, m);
    end
    waitClk(6);
    checkOutput("t6_req_pending", 32'(req), 1);
    #3 rst = 1'b1;
    #1 checkAllZero("t6_async");
    waitClk(4);
    enN  = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    waitClk(2);
    rst = 1'b0;
    waitClk(10);
    ackDelay = 1;
    rdataVal = 8'hC3;
    applyStimulus(8'h01, 8'h81, 8'h00, 24, 8'hC3, 1'b1, 1'b0);
    checkOutput("t6_halt_after", 32'(halt), 0);

    waitClk(20);
    checkOutput("busq_empty", 32'(busQ.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
